// File: rtl/udp_tx_scheduler_if.sv
// Bundles the channel FIFO ports and the MAC/UDP stack ports of udp_tx_scheduler.
// The master modport is the scheduler's view. The slave modport is the view of the FIFOs and the stack.
interface udp_tx_scheduler_if;
  logic [10:0] ch0_data_count;
  logic [15:0] ch0_length;
  logic [7:0]  ch0_data;
  logic        ch0_rd_en;
  logic [10:0] ch1_data_count;
  logic [15:0] ch1_length;
  logic [7:0]  ch1_data;
  logic        ch1_rd_en;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data;
  logic [15:0] udp_send_data_length;
  logic [15:0] identify_code;
  logic        udp_tx_req;
  logic        arp_request_req;
  logic        mac_send_end;
  logic        arp_found;
  logic        mac_not_exist;
  logic        active_ch;
  logic        busy;
  logic        err_timeout;

  modport master (
    input  ch0_data_count, ch0_length, ch0_data,
    input  ch1_data_count, ch1_length, ch1_data,
    input  fifo_rd_en, mac_send_end, arp_found, mac_not_exist,
    output ch0_rd_en, ch1_rd_en, fifo_data, udp_send_data_length, identify_code,
    output udp_tx_req, arp_request_req, active_ch, busy, err_timeout
  );

  modport slave (
    output ch0_data_count, ch0_length, ch0_data,
    output ch1_data_count, ch1_length, ch1_data,
    output fifo_rd_en, mac_send_end, arp_found, mac_not_exist,
    input  ch0_rd_en, ch1_rd_en, fifo_data, udp_send_data_length, identify_code,
    input  udp_tx_req, arp_request_req, active_ch, busy, err_timeout
  );
endinterface

// File: rtl/udp_tx_scheduler.sv
// Sequences start-up ARP resolution, then shares one UDP transmit path between two
// byte-stream channels round-robin. It re-runs ARP when the peer MAC is lost.
module udp_tx_scheduler #(
  parameter logic [31:0] INIT_WAIT    = 32'd1250000,
  parameter logic [31:0] ARP_RETRY    = 32'd125000000,
  parameter logic [31:0] SEND_TIMEOUT = 32'd125000,
  parameter logic [31:0] IFG_CYCLES   = 32'd16
) (
  input logic               gmii_tx_clk,
  input logic               rst_n,
  udp_tx_scheduler_if.master bus
);

  typedef enum logic [3:0] {
    ST_INIT, ST_ARP_REQ, ST_ARP_SEND, ST_ARP_WAIT, ST_ARB,
    ST_REQ, ST_SEND, ST_GAP, ST_CHECK_ARP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        active_ch_q, active_ch_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] length_q, length_d;
  logic [15:0] identify_code_q, identify_code_d;

  logic ch0_eligible, ch1_eligible, grant_valid, grant_ch, timeout, counting;
  logic arp_req, tx_req, busy, err_timeout, send_rd;

  assign ch0_eligible = (bus.ch0_length != 16'd0) && ({5'd0, bus.ch0_data_count} >= bus.ch0_length);
  assign ch1_eligible = (bus.ch1_length != 16'd0) && ({5'd0, bus.ch1_data_count} >= bus.ch1_length);
  assign grant_valid  = ch0_eligible | ch1_eligible;
  // On a tie, the channel that did not win last time takes the grant.
  assign grant_ch     = (ch0_eligible && ch1_eligible) ? ~last_grant_q : ch1_eligible;
  assign timeout      = (wait_cnt_q == SEND_TIMEOUT);

  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:      if (wait_cnt_q == INIT_WAIT) state_d = ST_ARP_REQ;
      ST_ARP_REQ:   state_d = ST_ARP_SEND;
      ST_ARP_SEND: begin
        if (bus.mac_send_end) state_d = ST_ARP_WAIT;
        else if (timeout)     state_d = ST_ARP_REQ;
      end
      ST_ARP_WAIT: begin
        if (bus.arp_found)              state_d = ST_ARB;
        else if (wait_cnt_q == ARP_RETRY) state_d = ST_ARP_REQ;
      end
      ST_ARB:       if (grant_valid) state_d = ST_REQ;
      ST_REQ:       state_d = ST_SEND;
      ST_SEND:      if (bus.mac_send_end || timeout) state_d = ST_GAP;
      ST_GAP:       if (wait_cnt_q == IFG_CYCLES - 32'd1) state_d = ST_CHECK_ARP;
      ST_CHECK_ARP: state_d = bus.mac_not_exist ? ST_ARP_REQ : ST_ARB;
      default:      state_d = ST_INIT;
    endcase
  end

  always_comb begin
    counting = (state_q == ST_INIT) || (state_q == ST_ARP_SEND) || (state_q == ST_ARP_WAIT) ||
               (state_q == ST_SEND) || (state_q == ST_GAP);
    wait_cnt_d      = (state_d != state_q) ? 32'd0 : (counting ? wait_cnt_q + 32'd1 : wait_cnt_q);
    active_ch_d     = active_ch_q;
    last_grant_d    = last_grant_q;
    length_d        = length_q;
    identify_code_d = identify_code_q;
    if (state_q == ST_ARB && grant_valid) begin
      active_ch_d  = grant_ch;
      last_grant_d = grant_ch;
      length_d     = grant_ch ? bus.ch1_length : bus.ch0_length;
    end
    // A timed-out frame was never confirmed sent, so it does not consume an identifier.
    if (state_q == ST_SEND && bus.mac_send_end) identify_code_d = identify_code_q + 16'd1;
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) begin
      wait_cnt_q      <= 32'd0;
      active_ch_q     <= 1'b0;
      last_grant_q    <= 1'b1;
      length_q        <= 16'd0;
      identify_code_q <= 16'd0;
    end else begin
      wait_cnt_q      <= wait_cnt_d;
      active_ch_q     <= active_ch_d;
      last_grant_q    <= last_grant_d;
      length_q        <= length_d;
      identify_code_q <= identify_code_d;
    end
  end

  always_comb begin
    arp_req     = (state_q == ST_ARP_REQ);
    tx_req      = (state_q == ST_REQ);
    busy        = (state_q == ST_ARP_SEND) || (state_q == ST_SEND);
    err_timeout = busy && timeout && !bus.mac_send_end;
    // Gating with rst_n keeps strobes off the FIFOs while reset is held, before the state clears.
    send_rd     = bus.fifo_rd_en && rst_n && (state_q == ST_SEND);
  end

  assign bus.arp_request_req      = arp_req;
  assign bus.udp_tx_req           = tx_req;
  assign bus.busy                 = busy;
  assign bus.err_timeout          = err_timeout;
  assign bus.ch0_rd_en            = send_rd & ~active_ch_q;
  assign bus.ch1_rd_en            = send_rd & active_ch_q;
  assign bus.fifo_data            = active_ch_q ? bus.ch1_data : bus.ch0_data;
  assign bus.active_ch            = active_ch_q;
  assign bus.udp_send_data_length = length_q;
  assign bus.identify_code        = identify_code_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: directed stimulus pushes expected pulses into queues,
// and a negedge monitor pops and compares them whenever the DUT raises a request or an error.
module tb_udp_tx_scheduler;
  localparam logic [31:0] INIT_WAIT    = 32'd20;
  localparam logic [31:0] ARP_RETRY    = 32'd50;
  localparam logic [31:0] SEND_TIMEOUT = 32'd1100;
  localparam logic [31:0] IFG_CYCLES   = 32'd16;
  localparam int EV_TX = 0, EV_ARP = 1, EV_TO = 2;

  logic gmii_tx_clk = 1'b0;
  logic rst_n = 1'b0;

  udp_tx_scheduler_if bus ();

  udp_tx_scheduler #(
    .INIT_WAIT(INIT_WAIT), .ARP_RETRY(ARP_RETRY),
    .SEND_TIMEOUT(SEND_TIMEOUT), .IFG_CYCLES(IFG_CYCLES)
  ) dut (
    .gmii_tx_clk(gmii_tx_clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  typedef struct { int cyc; logic ch; logic [15:0] len; logic [15:0] id; } tx_exp_t;
  typedef struct { int cyc; logic [15:0] id; } to_exp_t;

  tx_exp_t tx_q[$];
  int      arp_q[$];
  to_exp_t to_q[$];
  tx_exp_t tx_e;
  to_exp_t to_e;
  int      arp_e;
  int cyc = 0, checks = 0, errors = 0, tx_seen = 0;
  int c0, c1, r, base;
  logic tx_prev = 1'b0, arp_prev = 1'b0;

  always @(posedge gmii_tx_clk) cyc <= cyc + 1;

  always @(negedge gmii_tx_clk) begin
    if (bus.udp_tx_req) begin
      tx_seen++;
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL tx_req: got unexpected pulse ch=%0d len=%0d id=0x%0h cyc=%0d, expected none",
                 bus.active_ch, bus.udp_send_data_length, bus.identify_code, cyc);
      end else begin
        tx_e = tx_q.pop_front();
        if (bus.active_ch !== tx_e.ch || bus.udp_send_data_length !== tx_e.len ||
            bus.identify_code !== tx_e.id || (tx_e.cyc >= 0 && cyc != tx_e.cyc) ||
            bus.arp_request_req || tx_prev) begin
          errors++;
          $display("[TB] FAIL tx_req: got ch=%0d len=%0d id=0x%0h cyc=%0d arp=%0d prev=%0d, expected ch=%0d len=%0d id=0x%0h cyc=%0d arp=0 prev=0",
                   bus.active_ch, bus.udp_send_data_length, bus.identify_code, cyc,
                   bus.arp_request_req, tx_prev, tx_e.ch, tx_e.len, tx_e.id, tx_e.cyc);
        end
      end
    end
    if (bus.arp_request_req) begin
      checks++;
      arp_e = (arp_q.size() == 0) ? -1 : arp_q.pop_front();
      if (arp_e != cyc || bus.udp_tx_req || arp_prev) begin
        errors++;
        $display("[TB] FAIL arp_req: got cyc=%0d tx=%0d prev=%0d, expected cyc=%0d tx=0 prev=0",
                 cyc, bus.udp_tx_req, arp_prev, arp_e);
      end
    end
    if (bus.err_timeout) begin
      checks++;
      if (to_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL err_timeout: got unexpected pulse cyc=%0d, expected none", cyc);
      end else begin
        to_e = to_q.pop_front();
        if (to_e.cyc != cyc || bus.identify_code !== to_e.id) begin
          errors++;
          $display("[TB] FAIL err_timeout: got cyc=%0d id=0x%0h, expected cyc=%0d id=0x%0h",
                   cyc, bus.identify_code, to_e.cyc, to_e.id);
        end
      end
    end
    tx_prev  = bus.udp_tx_req;
    arp_prev = bus.arp_request_req;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] l0, input logic [10:0] n0,
                               input logic [15:0] l1, input logic [10:0] n1);
    bus.ch0_length = l0; bus.ch0_data_count = n0;
    bus.ch1_length = l1; bus.ch1_data_count = n1;
  endtask

  task automatic pushTx(input int c, input logic ch, input logic [15:0] len, input logic [15:0] id);
    tx_exp_t t;
    t.cyc = c; t.ch = ch; t.len = len; t.id = id;
    tx_q.push_back(t);
  endtask

  function automatic logic evHigh(input int kind);
    case (kind)
      EV_TX:   return bus.udp_tx_req;
      EV_ARP:  return bus.arp_request_req;
      default: return bus.err_timeout;
    endcase
  endfunction

  task automatic waitEvent(input int kind, input int limit);
    int n = 0;
    do begin
      @(negedge gmii_tx_clk);
      n++;
    end while (!evHigh(kind) && n < limit);
    checkOutput($sformatf("wait_event_%0d", kind), {31'd0, evHigh(kind)}, 32'd1);
  endtask

  task automatic pulseMacEnd();
    bus.mac_send_end = 1'b1;
    @(negedge gmii_tx_clk);
    bus.mac_send_end = 1'b0;
  endtask

  task automatic pulseArpFound();
    bus.arp_found = 1'b1;
    @(negedge gmii_tx_clk);
    bus.arp_found = 1'b0;
  endtask

  task automatic enterSend(input logic exp_ch);
    bus.fifo_rd_en = 1'b1;
    #1;
    checkOutput("rd_outside_send", {30'd0, bus.ch0_rd_en, bus.ch1_rd_en}, 32'd0);
    checkOutput("fifo_data", {24'd0, bus.fifo_data}, exp_ch ? 32'h5A : 32'hA5);
    @(negedge gmii_tx_clk);
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic streamData(input int n, output int s0, output int s1);
    s0 = 0; s1 = 0;
    for (int i = 0; i < n; i++) begin
      bus.fifo_rd_en = 1'b1;
      #1;
      s0 += int'(bus.ch0_rd_en);
      s1 += int'(bus.ch1_rd_en);
      @(negedge gmii_tx_clk);
    end
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic endPacket(input logic [15:0] exp_id);
    pulseMacEnd();
    checkOutput("identify_after_end", {16'd0, bus.identify_code}, {16'd0, exp_id});
    checkOutput("busy_in_gap", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic runPacket(input logic exp_ch, input int n, input logic [15:0] exp_id_after);
    int s0, s1;
    waitEvent(EV_TX, 3000);
    enterSend(exp_ch);
    streamData(n, s0, s1);
    checkOutput("ch0_strobes", s0, exp_ch ? 0 : n);
    checkOutput("ch1_strobes", s1, exp_ch ? n : 0);
    endPacket(exp_id_after);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    applyStimulus(16'd0, 11'd0, 16'd0, 11'd0);
    bus.ch0_data = 8'hA5; bus.ch1_data = 8'h5A;
    bus.fifo_rd_en = 1'b1; bus.mac_send_end = 1'b0;
    bus.arp_found = 1'b0; bus.mac_not_exist = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge gmii_tx_clk);
    checkOutput("reset_arp_req", {31'd0, bus.arp_request_req}, 32'd0);
    checkOutput("reset_tx_req", {31'd0, bus.udp_tx_req}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.err_timeout}, 32'd0);
    checkOutput("reset_id", {16'd0, bus.identify_code}, 32'd0);
    checkOutput("reset_len", {16'd0, bus.udp_send_data_length}, 32'd0);
    checkOutput("reset_active", {31'd0, bus.active_ch}, 32'd0);
    checkOutput("reset_rd_en", {30'd0, bus.ch0_rd_en, bus.ch1_rd_en}, 32'd0);
    checkOutput("reset_fifo_data", {24'd0, bus.fifo_data}, 32'hA5);
    bus.fifo_rd_en = 1'b0;

    // INIT holds wait_cnt 0..INIT_WAIT, so the ARP request appears INIT_WAIT+1 edges after release.
    rst_n = 1'b1;
    arp_q.push_back(cyc + int'(INIT_WAIT) + 1);
    repeat (5) @(negedge gmii_tx_clk);
    pulseMacEnd();
    waitEvent(EV_ARP, 100);
    @(negedge gmii_tx_clk);
    checkOutput("arp_send_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("arp_pulse_width", {31'd0, bus.arp_request_req}, 32'd0);
    pulseArpFound();

    // ARP_WAIT is entered on the next edge and retries once wait_cnt reaches ARP_RETRY.
    arp_q.push_back(cyc + 1 + int'(ARP_RETRY) + 1);
    pulseMacEnd();
    waitEvent(EV_ARP, 200);
    @(negedge gmii_tx_clk);
    pulseMacEnd();
    applyStimulus(16'd1000, 11'd1000, 16'd0, 11'd0);
    @(negedge gmii_tx_clk);
    pushTx(cyc + 2, 1'b0, 16'd1000, 16'd0);
    pulseArpFound();
    runPacket(1'b0, 1000, 16'd1);

    applyStimulus(16'd1000, 11'd999, 16'd0, 11'd2000);
    base = tx_seen;
    repeat (25) @(negedge gmii_tx_clk);
    pulseMacEnd();
    repeat (15) @(negedge gmii_tx_clk);
    checkOutput("no_grant_count_short", tx_seen, base);
    applyStimulus(16'd0, 11'd2000, 16'd0, 11'd0);
    repeat (20) @(negedge gmii_tx_clk);
    checkOutput("no_grant_zero_length", tx_seen, base);

    // Timeout then lost MAC: GAP lasts IFG_CYCLES, CHECK_ARP one cycle, then ARP_REQ.
    applyStimulus(16'd0, 11'd0, 16'd32, 11'd32);
    pushTx(-1, 1'b1, 16'd32, 16'd1);
    waitEvent(EV_TX, 100);
    r = cyc;
    begin
      to_exp_t t;
      t.cyc = r + 1 + int'(SEND_TIMEOUT); t.id = 16'd1;
      to_q.push_back(t);
    end
    arp_q.push_back(r + int'(SEND_TIMEOUT) + int'(IFG_CYCLES) + 3);
    enterSend(1'b1);
    applyStimulus(16'd0, 11'd0, 16'd0, 11'd0);
    checkOutput("len_latched_fault", {16'd0, bus.udp_send_data_length}, 32'd32);
    streamData(32, c0, c1);
    checkOutput("fault_ch1_strobes", c1, 32);
    checkOutput("fault_ch0_strobes", c0, 0);
    waitEvent(EV_TO, 2000);
    bus.mac_not_exist = 1'b1;
    @(negedge gmii_tx_clk);
    checkOutput("id_after_timeout", {16'd0, bus.identify_code}, 32'd1);
    waitEvent(EV_ARP, 100);
    bus.mac_not_exist = 1'b0;
    @(negedge gmii_tx_clk);
    pulseMacEnd();
    pulseArpFound();

    force dut.identify_code_q = 16'hFFFF;
    @(negedge gmii_tx_clk);
    release dut.identify_code_q;
    @(negedge gmii_tx_clk);
    checkOutput("id_preset", {16'd0, bus.identify_code}, 32'hFFFF);
    pushTx(-1, 1'b1, 16'd16, 16'hFFFF);
    applyStimulus(16'd0, 11'd0, 16'd16, 11'd16);
    runPacket(1'b1, 16, 16'h0000);

    // Both eligible throughout; the last grant was ch1, so ch0 leads.
    applyStimulus(16'd200, 11'd300, 16'd64, 11'd100);
    pushTx(-1, 1'b0, 16'd200, 16'd0);
    pushTx(-1, 1'b1, 16'd64, 16'd1);
    pushTx(-1, 1'b0, 16'd200, 16'd2);
    pushTx(-1, 1'b1, 16'd80, 16'd3);
    runPacket(1'b0, 200, 16'd1);
    waitEvent(EV_TX, 3000);
    enterSend(1'b1);
    streamData(32, c0, c1);
    bus.ch1_length = 16'd80;
    #1;
    checkOutput("len_stable_mid_send", {16'd0, bus.udp_send_data_length}, 32'd64);
    r = c1;
    streamData(32, c0, c1);
    checkOutput("rr_ch1_strobes", r + c1, 64);
    endPacket(16'd2);
    runPacket(1'b0, 200, 16'd3);
    runPacket(1'b1, 80, 16'd4);

    pushTx(-1, 1'b0, 16'd200, 16'd4);
    waitEvent(EV_TX, 3000);
    enterSend(1'b0);
    streamData(10, c0, c1);
    bus.fifo_rd_en = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("rd_en_in_reset", {30'd0, bus.ch0_rd_en, bus.ch1_rd_en}, 32'd0);
    @(negedge gmii_tx_clk);
    checkOutput("midreset_outputs",
                {bus.identify_code, bus.udp_send_data_length[9:0], bus.active_ch, bus.busy,
                 bus.udp_tx_req, bus.arp_request_req, bus.err_timeout, bus.ch0_rd_en},
                32'd0);
    checkOutput("midreset_len", {16'd0, bus.udp_send_data_length}, 32'd0);
    bus.fifo_rd_en = 1'b0;
    applyStimulus(16'd0, 11'd0, 16'd0, 11'd0);
    repeat (2) @(negedge gmii_tx_clk);
    rst_n = 1'b1;
    arp_q.push_back(cyc + int'(INIT_WAIT) + 1);
    waitEvent(EV_ARP, 100);
    @(negedge gmii_tx_clk);

    checkOutput("scoreboard_drained", tx_q.size() + arp_q.size() + to_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
